// File: rtl/visor_uart_pkg.sv
// Shared types and register map for the visor debug console UART.
package visor_uart_pkg;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_e;

  localparam logic [15:0] UART_DATA_OFS   = 16'd0;
  localparam logic [15:0] UART_CTRL_OFS   = 16'd1;
  localparam int          UART_CTRL_FLUSH = 0;

endpackage

// File: rtl/visor_uart_tx_if.sv
// Write-only Avalon-MM link between the visor master and its console UART.
interface visor_uart_tx_if;

  logic [15:0] av_address;
  logic [15:0] av_writedata;
  logic        av_write;
  logic        av_waitrequest;

  modport master (
    output av_address,
    output av_writedata,
    output av_write,
    input  av_waitrequest
  );

  modport slave (
    input  av_address,
    input  av_writedata,
    input  av_write,
    output av_waitrequest
  );

endinterface

// File: rtl/visor_byte_fifo.sv
// Single-clock byte FIFO; the head entry is visible on dout without a read cycle.
module visor_byte_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                     sysclk,
  input  logic                     sysreset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [7:0]               din,
  output logic [7:0]               dout,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign do_push = push && (count != FULL);
  assign do_pop  = pop && (count != '0);
  assign dout    = (count != '0) ? mem[rd_ptr] : 8'h00;

  always_ff @(posedge sysclk) begin
    if (do_push && !flush) begin
      mem[wr_ptr] <= din;
    end
  end

  // Flush wins over everything: a byte popped on the same edge has already left via dout.
  always_ff @(posedge sysclk or posedge sysreset) begin
    if (sysreset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/visor_uart_tx.sv
// Avalon-MM write-only console: buffers firmware bytes and sends them as 8N1 frames on txd.
module visor_uart_tx
  import visor_uart_pkg::*;
#(
  parameter int          CLK_HZ     = 50000000,
  parameter int          BAUD       = 115200,
  parameter int          DIVISOR    = CLK_HZ / BAUD,
  parameter int          FIFO_DEPTH = 16,
  parameter logic [15:0] BASE_ADDR  = 16'h0000
) (
  input  logic                          sysclk,
  input  logic                          sysreset,
  visor_uart_tx_if.slave                av,
  output logic                          txd,
  output logic                          tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int DW = $clog2(DIVISOR);
  localparam logic [15:0]   DATA_ADDR  = BASE_ADDR + UART_DATA_OFS;
  localparam logic [15:0]   CTRL_ADDR  = BASE_ADDR + UART_CTRL_OFS;
  localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);
  localparam logic [DW-1:0] RELOAD     = DW'(DIVISOR - 1);

  uart_state_e   state;
  logic [DW-1:0] baud_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic [7:0]    fifo_dout;
  logic          hit_data;
  logic          hit_ctrl;
  logic          stall;
  logic          accept;
  logic          push;
  logic          flush;
  logic          pop;
  logic          fifo_nonempty;
  logic          bit_done;
  logic          unused_bits;

  assign hit_data      = (av.av_address == DATA_ADDR);
  assign hit_ctrl      = (av.av_address == CTRL_ADDR);
  assign stall         = av.av_write && hit_data && (fifo_count == FULL_COUNT);
  assign av.av_waitrequest = stall;
  assign accept        = av.av_write && !stall;
  assign push          = accept && hit_data;
  assign flush         = accept && hit_ctrl && av.av_writedata[UART_CTRL_FLUSH];
  assign fifo_nonempty = (fifo_count != '0);
  assign bit_done      = (baud_cnt == '0);
  assign pop           = fifo_nonempty && ((state == IDLE) || (state == STOP && bit_done));
  assign tx_busy       = (state != IDLE) || fifo_nonempty;
  assign unused_bits   = ^av.av_writedata[15:8];

  visor_byte_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .sysclk   (sysclk),
    .sysreset (sysreset),
    .push     (push),
    .pop      (pop),
    .flush    (flush),
    .din      (av.av_writedata[7:0]),
    .dout     (fifo_dout),
    .count    (fifo_count)
  );

  // STOP chains straight into START when more data is waiting, so frames run gap-free.
  always_ff @(posedge sysclk or posedge sysreset) begin
    if (sysreset) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      txd      <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          txd <= 1'b1;
          if (fifo_nonempty) begin
            shift    <= fifo_dout;
            state    <= START;
            txd      <= 1'b0;
            baud_cnt <= RELOAD;
          end
        end
        START: begin
          if (bit_done) begin
            state    <= DATA;
            bit_idx  <= '0;
            txd      <= shift[0];
            baud_cnt <= RELOAD;
          end else begin
            baud_cnt <= baud_cnt - 1'b1;
          end
        end
        DATA: begin
          if (bit_done) begin
            baud_cnt <= RELOAD;
            if (bit_idx == 3'd7) begin
              state <= STOP;
              txd   <= 1'b1;
            end else begin
              shift   <= shift >> 1;
              txd     <= shift[1];
              bit_idx <= bit_idx + 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt - 1'b1;
          end
        end
        STOP: begin
          if (bit_done) begin
            if (fifo_nonempty) begin
              shift    <= fifo_dout;
              state    <= START;
              txd      <= 1'b0;
              baud_cnt <= RELOAD;
            end else begin
              state <= IDLE;
              txd   <= 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt - 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          txd   <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_visor_uart_tx.sv
// Directed bench for visor_uart_tx: a serial monitor decodes txd against a byte scoreboard.
module tb_visor_uart_tx;

  localparam int          CLK_HZ     = 1000;
  localparam int          BAUD       = 100;
  localparam int          DIVISOR    = 10;
  localparam int          FIFO_DEPTH = 4;
  localparam logic [15:0] BASE_ADDR  = 16'h0040;
  localparam logic [15:0] DATA_A     = BASE_ADDR;
  localparam logic [15:0] CTRL_A     = BASE_ADDR + 16'd1;

  logic       sysclk = 1'b0;
  logic       sysreset;
  logic       txd;
  logic       tx_busy;
  logic [2:0] fifo_count;

  visor_uart_tx_if av_bus ();

  visor_uart_tx #(
    .CLK_HZ     (CLK_HZ),
    .BAUD       (BAUD),
    .DIVISOR    (DIVISOR),
    .FIFO_DEPTH (FIFO_DEPTH),
    .BASE_ADDR  (BASE_ADDR)
  ) dut (
    .sysclk     (sysclk),
    .sysreset   (sysreset),
    .av         (av_bus),
    .txd        (txd),
    .tx_busy    (tx_busy),
    .fifo_count (fifo_count)
  );

  always #5 sysclk = ~sysclk;

  int         vectors = 0;
  int         miscompares = 0;
  int         cycle = 0;
  logic [7:0] exp_q [$];
  int         starts [$];
  int         frames_rx = 0;
  bit         rx_active = 0;
  int         rx_tick = 0;
  logic [7:0] rx_shift = '0;
  logic [7:0] rx_exp = '0;
  bit         rx_exp_valid = 0;

  always @(posedge sysclk) cycle++;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Serial receiver: samples mid-bit and pops the scoreboard when a start bit appears.
  always @(negedge sysclk) begin
    if (sysreset) begin
      rx_active = 0;
    end else if (!rx_active) begin
      if (txd === 1'b0) begin
        rx_active = 1;
        rx_tick = 0;
        starts.push_back(cycle);
        rx_exp_valid = (exp_q.size() != 0);
        if (rx_exp_valid) rx_exp = exp_q.pop_front();
      end
    end else begin
      rx_tick++;
      if (rx_tick == 4) begin
        checkOutput("rx_start_bit", {31'd0, txd}, 32'd0);
      end else if (rx_tick >= 14 && rx_tick <= 84 && (rx_tick - 14) % 10 == 0) begin
        rx_shift[(rx_tick - 14) / 10] = txd;
      end else if (rx_tick == 94) begin
        checkOutput("rx_stop_bit", {31'd0, txd}, 32'd1);
        checkOutput("rx_expected_frame", {31'd0, rx_exp_valid}, 32'd1);
        if (rx_exp_valid) checkOutput("rx_byte", {24'd0, rx_shift}, {24'd0, rx_exp});
        frames_rx++;
        rx_active = 0;
      end
    end
  end

  task automatic applyStimulus(input logic [15:0] addr, input logic [15:0] data,
                               output int stall, output logic rel_txd, output logic prev_txd);
    av_bus.av_address   = addr;
    av_bus.av_writedata = data;
    av_bus.av_write     = 1'b1;
    #1;
    stall    = 0;
    prev_txd = txd;
    while (av_bus.av_waitrequest === 1'b1 && stall < 300) begin
      prev_txd = txd;
      @(negedge sysclk);
      stall++;
    end
    rel_txd = txd;
    if (av_bus.av_waitrequest !== 1'b0) begin
      checkOutput("write_stall_timeout", {31'd0, av_bus.av_waitrequest}, 32'd0);
    end else begin
      if (addr == DATA_A) exp_q.push_back(data[7:0]);
      if (addr == CTRL_A && data[0]) exp_q.delete();
    end
    @(negedge sysclk);
    av_bus.av_write = 1'b0;
  endtask

  task automatic waitIdle(input int limit);
    int n = 0;
    while ((tx_busy || rx_active) && n < limit) begin
      @(negedge sysclk);
      n++;
    end
    if (n >= limit) checkOutput("idle_timeout", {31'd0, tx_busy}, 32'd0);
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: still running at %0t, required to finish earlier", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int         st;
    logic       rel;
    logic       prv;
    int         n0;
    int         f0;
    logic [9:0] frame;

    sysreset            = 1'b1;
    av_bus.av_write     = 1'b0;
    av_bus.av_address   = '0;
    av_bus.av_writedata = '0;
    repeat (3) @(negedge sysclk);
    checkOutput("reset_txd", {31'd0, txd}, 32'd1);
    checkOutput("reset_busy", {31'd0, tx_busy}, 32'd0);
    checkOutput("reset_count", {29'd0, fifo_count}, 32'd0);
    checkOutput("reset_wait", {31'd0, av_bus.av_waitrequest}, 32'd0);
    #2 sysreset = 1'b0;
    @(negedge sysclk);

    $display("[TB] single frame 0xA5");
    frame = {1'b1, 8'hA5, 1'b0};
    applyStimulus(DATA_A, 16'h12A5, st, rel, prv);
    checkOutput("t1_txd_before_start", {31'd0, txd}, 32'd1);
    checkOutput("t1_count_accepted", {29'd0, fifo_count}, 32'd1);
    checkOutput("t1_busy_accepted", {31'd0, tx_busy}, 32'd1);
    for (int k = 0; k < 100; k++) begin
      @(negedge sysclk);
      checkOutput("t1_line_bit", {31'd0, txd}, {31'd0, frame[k / 10]});
    end
    checkOutput("t1_busy_in_stop", {31'd0, tx_busy}, 32'd1);
    @(negedge sysclk);
    checkOutput("t1_txd_idle", {31'd0, txd}, 32'd1);
    checkOutput("t1_busy_clear", {31'd0, tx_busy}, 32'd0);

    $display("[TB] back-to-back 0x00 0xFF");
    n0 = starts.size();
    applyStimulus(DATA_A, 16'h0000, st, rel, prv);
    applyStimulus(DATA_A, 16'h00FF, st, rel, prv);
    waitIdle(400);
    checkOutput("t2_frames", starts.size() - n0, 32'd2);
    if (starts.size() >= n0 + 2) checkOutput("t2_start_spacing", starts[n0 + 1] - starts[n0], 32'd100);

    $display("[TB] fill FIFO and stall");
    n0 = starts.size();
    applyStimulus(DATA_A, 16'h003C, st, rel, prv);
    repeat (20) @(negedge sysclk);
    applyStimulus(DATA_A, 16'h0011, st, rel, prv);
    applyStimulus(DATA_A, 16'h0022, st, rel, prv);
    applyStimulus(DATA_A, 16'h0033, st, rel, prv);
    applyStimulus(DATA_A, 16'h0044, st, rel, prv);
    checkOutput("t3_full_count", {29'd0, fifo_count}, 32'd4);
    av_bus.av_address   = DATA_A;
    av_bus.av_writedata = 16'h0055;
    av_bus.av_write     = 1'b1;
    #1 checkOutput("t3_waitrequest_full", {31'd0, av_bus.av_waitrequest}, 32'd1);
    applyStimulus(DATA_A, 16'h0055, st, rel, prv);
    checkOutput("t3_was_stalled", {31'd0, st > 0}, 32'd1);
    checkOutput("t3_release_on_start", {31'd0, rel}, 32'd0);
    checkOutput("t3_stop_before_release", {31'd0, prv}, 32'd1);
    checkOutput("t3_count_after", {29'd0, fifo_count}, exp_q.size());
    waitIdle(1200);
    checkOutput("t3_frames", starts.size() - n0, 32'd6);

    $display("[TB] flush mid-frame");
    n0 = starts.size();
    applyStimulus(DATA_A, 16'h0061, st, rel, prv);
    applyStimulus(DATA_A, 16'h0062, st, rel, prv);
    applyStimulus(DATA_A, 16'h0063, st, rel, prv);
    repeat (30) @(negedge sysclk);
    checkOutput("t4_count_queued", {29'd0, fifo_count}, 32'd2);
    applyStimulus(CTRL_A, 16'h0001, st, rel, prv);
    checkOutput("t4_count_flushed", {29'd0, fifo_count}, 32'd0);
    checkOutput("t4_busy_frame_on", {31'd0, tx_busy}, 32'd1);
    waitIdle(300);
    repeat (150) @(negedge sysclk);
    checkOutput("t4_frames", starts.size() - n0, 32'd1);
    checkOutput("t4_busy_clear", {31'd0, tx_busy}, 32'd0);

    $display("[TB] reset mid-frame");
    n0 = starts.size();
    f0 = frames_rx;
    applyStimulus(DATA_A, 16'h0071, st, rel, prv);
    applyStimulus(DATA_A, 16'h0072, st, rel, prv);
    applyStimulus(DATA_A, 16'h0073, st, rel, prv);
    repeat (40) @(negedge sysclk);
    checkOutput("t5_count_queued", {29'd0, fifo_count}, 32'd2);
    #2 sysreset = 1'b1;
    exp_q.delete();
    #1;
    checkOutput("t5_txd_reset", {31'd0, txd}, 32'd1);
    checkOutput("t5_count_reset", {29'd0, fifo_count}, 32'd0);
    checkOutput("t5_busy_reset", {31'd0, tx_busy}, 32'd0);
    @(negedge sysclk);
    #2 sysreset = 1'b0;
    repeat (200) @(negedge sysclk);
    checkOutput("t5_no_new_start", starts.size() - n0, 32'd1);
    checkOutput("t5_no_completed_frame", frames_rx - f0, 32'd0);
    checkOutput("t5_txd_idle", {31'd0, txd}, 32'd1);

    $display("[TB] unmapped address");
    n0 = starts.size();
    applyStimulus(BASE_ADDR + 16'd5, 16'h0041, st, rel, prv);
    checkOutput("t6_no_stall", st, 32'd0);
    checkOutput("t6_count", {29'd0, fifo_count}, 32'd0);
    for (int k = 0; k < 30; k++) begin
      @(negedge sysclk);
      checkOutput("t6_txd_high", {31'd0, txd}, 32'd1);
    end
    checkOutput("t6_no_frame", starts.size() - n0, 32'd0);
    checkOutput("t6_busy", {31'd0, tx_busy}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
